// File: rtl/fc_tensor_fetch.sv
// Fetches bias, weight, data tensors over burst reads into flat vectors; stalls on ar_ready/r_valid, holds until fc_take.
// Optional r_last protocol checking is enabled by defining FC_FETCH_RLAST_CHK_EN.
module fc_tensor_fetch #(
   parameter int         BATCH = 1,
   parameter int         FEAT  = 1,
   parameter int         OUTF  = 1,
   parameter int         BURST = 16,
   parameter logic [3:0] ARID  = 4'b1001
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic                       ar_valid,
   input  logic                       ar_ready,
   output logic [3:0]                 ar_id,
   output logic [3:0]                 ar_len,
   output logic [27:0]                ar_addr,
   input  logic                       r_valid,
   input  logic [3:0]                 r_id,
   input  logic                       r_last,
   input  logic [31:0]                r_data,
   output logic                       addr_rq,
   output logic [2:0]                 addr_type,
   input  logic [27:0]                init_addr,
   input  logic                       init_addr_en,
   output logic [BATCH*FEAT*32-1:0]   fc_data,
   output logic [FEAT*OUTF*32-1:0]    fc_weight,
   output logic [OUTF*32-1:0]         fc_bias,
   output logic                       fc_valid,
   input  logic                       fc_take,
   output logic                       rd_end,
   output logic                       err
);

   localparam int DSZ   = BATCH * FEAT;
   localparam int WSZ   = FEAT * OUTF;
   localparam int BSZ   = OUTF;
   localparam int MAXSZ = (DSZ > WSZ) ? ((DSZ > BSZ) ? DSZ : BSZ) : ((WSZ > BSZ) ? WSZ : BSZ);
   localparam int CW    = $clog2(MAXSZ + 1);

   typedef enum logic [2:0] {IDLE, ADDR, AR, RD, HOLD} state_t;
   typedef enum logic [1:0] {T_BIAS, T_WEIGHT, T_DATA} tensor_t;

   state_t                   state_q, state_d;
   tensor_t                  tsel_q;
   logic [CW-1:0]            cnt_q;
   logic [4:0]               beat_q;
   logic [4:0]               blen_q;
   logic [27:0]              addr_q;
   logic                     rd_end_q;
   logic [OUTF*32-1:0]       bias_q;
   logic [FEAT*OUTF*32-1:0]  weight_q;
   logic [BATCH*FEAT*32-1:0] data_q;

   logic [CW-1:0]            size_cur;
   logic [CW-1:0]            rem;
   logic [4:0]               blen_d;
   logic                     beat_ok;
   logic                     last_beat;
   logic                     tensor_last;

   always_comb begin
      size_cur = CW'(BSZ);
      case (tsel_q)
         T_WEIGHT: size_cur = CW'(WSZ);
         T_DATA:   size_cur = CW'(DSZ);
         default:  size_cur = CW'(BSZ);
      endcase
   end

   assign rem         = size_cur - cnt_q;
   assign blen_d      = (int'(rem) > BURST) ? 5'(BURST) : 5'(rem);
   assign beat_ok     = (state_q == RD) && r_valid && (r_id == ARID);
   // Burst end comes from the beat count alone; r_last never terminates a burst.
   assign last_beat   = beat_ok && (beat_q == blen_q - 5'd1);
   assign tensor_last = last_beat && (cnt_q == size_cur - CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      ar_valid  = 1'b0;
      addr_rq   = 1'b0;
      addr_type = 3'b000;
      fc_valid  = 1'b0;
      case (state_q)
         IDLE: state_d = ADDR;
         ADDR: begin
            addr_rq = 1'b1;
            case (tsel_q)
               T_WEIGHT: addr_type = 3'b010;
               T_DATA:   addr_type = 3'b001;
               default:  addr_type = 3'b100;
            endcase
            if (init_addr_en) state_d = AR;
         end
         AR: begin
            ar_valid = 1'b1;
            if (ar_ready) state_d = RD;
         end
         RD: begin
            if (last_beat) begin
               if (!tensor_last)          state_d = AR;
               else if (tsel_q == T_DATA) state_d = HOLD;
               else                       state_d = ADDR;
            end
         end
         HOLD: begin
            fc_valid = 1'b1;
            if (fc_take) state_d = ADDR;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ar_id   = ar_valid ? ARID : 4'd0;
   assign ar_len  = ar_valid ? 4'(blen_d - 5'd1) : 4'd0;
   assign ar_addr = addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tsel_q   <= T_BIAS;
         cnt_q    <= '0;
         beat_q   <= '0;
         blen_q   <= '0;
         addr_q   <= '0;
         rd_end_q <= 1'b0;
         bias_q   <= '0;
         weight_q <= '0;
         data_q   <= '0;
      end else begin
         rd_end_q <= (state_q == RD) && (state_d == HOLD);
         if ((state_q == ADDR) && init_addr_en) addr_q <= init_addr;
         if ((state_q == AR) && ar_ready) begin
            blen_q <= blen_d;
            beat_q <= '0;
         end
         if (beat_ok) begin
            beat_q <= beat_q + 5'd1;
            cnt_q  <= cnt_q + CW'(1);
            for (int k = 0; k < BSZ; k++)
               if (tsel_q == T_BIAS && cnt_q == CW'(k)) bias_q[k*32 +: 32] <= r_data;
            for (int k = 0; k < WSZ; k++)
               if (tsel_q == T_WEIGHT && cnt_q == CW'(k)) weight_q[k*32 +: 32] <= r_data;
            for (int k = 0; k < DSZ; k++)
               if (tsel_q == T_DATA && cnt_q == CW'(k)) data_q[k*32 +: 32] <= r_data;
            if (last_beat) addr_q <= addr_q + {21'd0, blen_q, 2'b00};
            if (tensor_last) begin
               cnt_q <= '0;
               if (tsel_q == T_BIAS) tsel_q <= T_WEIGHT;
               else                  tsel_q <= T_DATA;
            end
         end
         if ((state_q == HOLD) && fc_take) tsel_q <= T_BIAS;
      end
   end

   assign fc_bias   = bias_q;
   assign fc_weight = weight_q;
   assign fc_data   = data_q;
   assign rd_end    = rd_end_q;

`ifdef FC_FETCH_RLAST_CHK_EN
   logic err_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                             err_q <= 1'b0;
      else if (beat_ok && (r_last != last_beat)) err_q <= 1'b1;
   end
   assign err = err_q;
`else
   logic unused_rlast;
   assign unused_rlast = r_last;
   assign err          = 1'b0;
`endif

endmodule
